reg_delay_line_a: RTL and testbench

Parametrised multi-stage register delay line with per-stage valid bits, asynchronous active-low reset, enable-gated advance, synchronous flush and an occupancy counter. It is the reset-capable, depth-generalised successor to the single-stage enable register primitive in the Bluespec primitive library. Generated RTL uses it wherever a value must be delayed a fixed number of enabled cycles: retimed results, pipelined CSR side-effects and delayed kill signals.

---
 rtl/reg_delay_line_a_if.sv | 35 +++
 rtl/reg_delay_line_a.sv | 78 +++++++
 tb/tb_reg_delay_line_a.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reg_delay_line_a_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : reg_delay_line_a_if
// Description : Bus bundle for reg_delay_line_a. The master drives the advance,
//               flush and stage-0 data/valid; the slave (the delay line)
//               returns the last stage, occupancy count and empty flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface reg_delay_line_a_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
);
  // Count width: ceil(log2(DEPTH+1)), never below one bit.
  localparam int C_CW = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1;

  logic             EN;
  logic             CLR;
  logic [WIDTH-1:0] D_IN;
  logic             D_IN_VALID;
  logic [WIDTH-1:0] Q_OUT;
  logic             Q_OUT_VALID;
  logic [C_CW-1:0]  COUNT;
  logic             EMPTY;

  modport master (
    output EN, CLR, D_IN, D_IN_VALID,
    input  Q_OUT, Q_OUT_VALID, COUNT, EMPTY
  );

  modport slave (
    input  EN, CLR, D_IN, D_IN_VALID,
    output Q_OUT, Q_OUT_VALID, COUNT, EMPTY
  );
endinterface
`default_nettype wire

// File: rtl/reg_delay_line_a.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : reg_delay_line_a
// Description : DEPTH-stage register delay line with per-stage valid bits,
//               asynchronous active-low reset, enable-gated advance,
//               synchronous flush (CLR beats EN) and an occupancy counter.
//               All outputs come straight from registers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module reg_delay_line_a #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  reg_delay_line_a_if.slave  bus
);

  localparam int C_CW = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1;
  // One extra bit so an over/underflow is visible to the range check.
  localparam int C_NW = C_CW + 1;

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [C_CW-1:0]  r_cnt;
  logic             r_empty;
  logic [C_NW-1:0]  w_cnt_next;

  // Occupancy after an enabled advance: one in from D_IN, one out of the last stage.
  assign w_cnt_next = {1'b0, r_cnt} + C_NW'(bus.D_IN_VALID) - C_NW'(r_vld[DEPTH-1]);

  // Stage shift, valid tracking and counter; flush clears valids only, data is kept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= `BSV_ASSIGNMENT_DELAY INIT;
      end
      r_vld   <= `BSV_ASSIGNMENT_DELAY '0;
      r_cnt   <= `BSV_ASSIGNMENT_DELAY '0;
      r_empty <= `BSV_ASSIGNMENT_DELAY 1'b1;
    end else if (bus.CLR) begin
      r_vld   <= `BSV_ASSIGNMENT_DELAY '0;
      r_cnt   <= `BSV_ASSIGNMENT_DELAY '0;
      r_empty <= `BSV_ASSIGNMENT_DELAY 1'b1;
    end else if (bus.EN) begin
      r_data[0] <= `BSV_ASSIGNMENT_DELAY bus.D_IN;
      r_vld[0]  <= `BSV_ASSIGNMENT_DELAY bus.D_IN_VALID;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= `BSV_ASSIGNMENT_DELAY r_data[i-1];
        r_vld[i]  <= `BSV_ASSIGNMENT_DELAY r_vld[i-1];
      end
      r_cnt   <= `BSV_ASSIGNMENT_DELAY w_cnt_next[C_CW-1:0];
      r_empty <= `BSV_ASSIGNMENT_DELAY (w_cnt_next == '0);
    end
  end

  assign bus.Q_OUT       = r_data[DEPTH-1];
  assign bus.Q_OUT_VALID = r_vld[DEPTH-1];
  assign bus.COUNT       = r_cnt;
  assign bus.EMPTY       = r_empty;

`ifndef SYNTHESIS
  // The counter must stay within 0..DEPTH; a wrap shows up as a large value.
  always @(posedge CLK) begin
    if (RST_N && !bus.CLR && bus.EN) begin
      assert (w_cnt_next <= C_NW'(DEPTH))
        else $error("reg_delay_line_a: occupancy counter out of range (%0d)", w_cnt_next);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_delay_line_a.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_reg_delay_line_a
// Description : Self-checking bench for reg_delay_line_a. Instance A is
//               8-bit x 3 stages with INIT=8'hA5, instance B is 1-bit x 1
//               stage. Count/valid expectations come from a vector table;
//               output data is checked against a scoreboard queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_reg_delay_line_a;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  reg_delay_line_a_if #(.WIDTH(8), .DEPTH(3)) bus_a ();
  reg_delay_line_a_if #(.WIDTH(1), .DEPTH(1)) bus_b ();

  reg_delay_line_a #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) u_dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_a.slave)
  );

  reg_delay_line_a #(.WIDTH(1), .DEPTH(1), .INIT(1'b0)) u_dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] din;
    logic       dvld;
    logic [1:0] cnt;   // COUNT after the edge
    logic       qv;    // Q_OUT_VALID after the edge
  } vec_t;

  localparam int NV = 19;
  vec_t       vecs [NV];
  vec_t       v;
  logic [7:0] q_a [$];
  logic       q_b [$];
  logic [7:0] exp_d;
  logic       exp_b;
  logic       exp_qv_b;
  logic       dv_b;
  logic       en_b;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hard stop in case anything wedges.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // latency: one entry, then bubbles
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    // stall: EN low for two cycles after the first edge
    vecs[4]  = '{1'b1, 1'b0, 8'h22, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h99, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h98, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    // full stream 1..5
    vecs[10] = '{1'b1, 1'b0, 8'h01, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h02, 1'b1, 2'd2, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h03, 1'b1, 2'd3, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'h04, 1'b1, 2'd3, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 8'h05, 1'b1, 2'd3, 1'b1};
    // flush with EN and a valid 8'h77 offered at the same edge
    vecs[15] = '{1'b1, 1'b1, 8'h77, 1'b1, 2'd0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

    bus_a.EN = 1'b0; bus_a.CLR = 1'b0; bus_a.D_IN = '0; bus_a.D_IN_VALID = 1'b0;
    bus_b.EN = 1'b0; bus_b.CLR = 1'b0; bus_b.D_IN = '0; bus_b.D_IN_VALID = 1'b0;
    RST_N = 1'b1;

    // Reset asserted mid-cycle, no clock edge before sampling.
    #12 RST_N = 1'b0;
    #1;
    chk("rst_a_q",     32'(bus_a.Q_OUT),       32'hA5);
    chk("rst_a_qv",    32'(bus_a.Q_OUT_VALID), 32'd0);
    chk("rst_a_cnt",   32'(bus_a.COUNT),       32'd0);
    chk("rst_a_empty", 32'(bus_a.EMPTY),       32'd1);
    chk("rst_b_qv",    32'(bus_b.Q_OUT_VALID), 32'd0);
    chk("rst_b_cnt",   32'(bus_b.COUNT),       32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Table-driven run on instance A.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      bus_a.EN = v.en; bus_a.CLR = v.clr; bus_a.D_IN = v.din; bus_a.D_IN_VALID = v.dvld;
      if (v.clr) q_a.delete();
      else if (v.en && v.dvld) q_a.push_back(v.din);
      @(negedge CLK);
      chk($sformatf("a_cnt[%0d]", i),   32'(bus_a.COUNT),       32'(v.cnt));
      chk($sformatf("a_qv[%0d]", i),    32'(bus_a.Q_OUT_VALID), 32'(v.qv));
      chk($sformatf("a_empty[%0d]", i), 32'(bus_a.EMPTY),       32'(v.cnt == 2'd0));
      if (v.en && !v.clr && bus_a.Q_OUT_VALID) begin
        if (q_a.size() == 0) begin
          chk($sformatf("a_sb_underrun[%0d]", i), 32'd1, 32'd0);
        end else begin
          exp_d = q_a.pop_front();
          chk($sformatf("a_q[%0d]", i), 32'(bus_a.Q_OUT), 32'(exp_d));
        end
      end
    end
    chk("a_sb_leftover", 32'(q_a.size()), 32'd0);
    bus_a.EN = 1'b0; bus_a.D_IN_VALID = 1'b0;

    // Depth-1 instance: alternating valid, one hold cycle with the output valid.
    exp_qv_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dv_b = (i % 2 == 0);
      en_b = (i != 3);
      bus_b.EN = en_b; bus_b.D_IN_VALID = dv_b; bus_b.D_IN = 1'($urandom_range(0, 1));
      if (en_b) begin
        exp_qv_b = dv_b;
        if (dv_b) q_b.push_back(bus_b.D_IN);
      end
      @(negedge CLK);
      chk($sformatf("b_qv[%0d]", i),    32'(bus_b.Q_OUT_VALID), 32'(exp_qv_b));
      chk($sformatf("b_cnt[%0d]", i),   32'(bus_b.COUNT),       32'(exp_qv_b));
      chk($sformatf("b_empty[%0d]", i), 32'(bus_b.EMPTY),       32'(!exp_qv_b));
      if (en_b && bus_b.Q_OUT_VALID) begin
        if (q_b.size() == 0) begin
          chk($sformatf("b_sb_underrun[%0d]", i), 32'd1, 32'd0);
        end else begin
          exp_b = q_b.pop_front();
          chk($sformatf("b_q[%0d]", i), 32'(bus_b.Q_OUT), 32'(exp_b));
        end
      end
    end
    bus_b.EN = 1'b0; bus_b.D_IN_VALID = 1'b0;

    // Asynchronous reset in the middle of operation on A.
    bus_a.EN = 1'b1; bus_a.D_IN = 8'h5A; bus_a.D_IN_VALID = 1'b1;
    @(negedge CLK);
    bus_a.EN = 1'b0; bus_a.D_IN_VALID = 1'b0;
    chk("mid_pre_cnt", 32'(bus_a.COUNT), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_cnt",   32'(bus_a.COUNT),       32'd0);
    chk("mid_rst_qv",    32'(bus_a.Q_OUT_VALID), 32'd0);
    chk("mid_rst_empty", 32'(bus_a.EMPTY),       32'd1);
    chk("mid_rst_q",     32'(bus_a.Q_OUT),       32'hA5);
    @(negedge CLK);
    RST_N = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
